aes_encipher_block: RTL and testbench

Iterative AES encipher datapath that pairs with the decipher block in the AES core. It performs the initial AddRoundKey, Nr−1 full rounds and the final round for AES-128 and AES-256, one 32-bit S-box word per cycle. The S-box is external, shared with the key memory through the core's S-box mux. Round keys come from the key memory, indexed by the `round` output.

---
 rtl/aes_encipher_block.sv | 177 +++++++++++++++++
 tb/tb_aes_encipher_block.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher datapath: four column word registers, one S-box word per cycle.
// Define AES_ENC_SBOX_PARALLEL_EN to substitute all four words per cycle with internal S-boxes.

`ifdef AES_ENC_SBOX_PARALLEL_EN
module aes_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, followed by the affine transform.
  function automatic logic [7:0] sub_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    new_sboxw = {sub_byte(sboxw[31:24]), sub_byte(sboxw[23:16]),
                 sub_byte(sboxw[15:8]),  sub_byte(sboxw[7:0])};
  end

endmodule
`endif

module aes_encipher_block (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {CTRL_IDLE, CTRL_INIT, CTRL_SBOX, CTRL_MAIN} ctrl_t;

  ctrl_t             state_q, state_d;
  logic [0:3][31:0]  w_q, w_d;
  logic [3:0]        round_q, round_d;
  logic [1:0]        sword_q, sword_d;
  logic              ready_q, ready_d;
  logic [3:0]        nr;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
            b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [0:3][31:0] w);
    logic [0:3][31:0] ws;
    for (int c = 0; c < 4; c++) begin
      ws[c] = {w[c][31:24], w[(c + 1) % 4][23:16], w[(c + 2) % 4][15:8], w[(c + 3) % 4][7:0]};
    end
    return ws;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [0:3][31:0] w);
    return {mix_word(w[0]), mix_word(w[1]), mix_word(w[2]), mix_word(w[3])};
  endfunction

`ifdef AES_ENC_SBOX_PARALLEL_EN
  logic [0:3][31:0] sub_all;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .sboxw     (w_q[g]),
      .new_sboxw (sub_all[g])
    );
  end
`endif

  assign nr        = keylen ? 4'd14 : 4'd10;
  assign round     = round_q;
  assign new_block = w_q;
  assign ready     = ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CTRL_IDLE;
      w_q     <= '0;
      round_q <= 4'd0;
      sword_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      round_q <= round_d;
      sword_q <= sword_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    round_d = round_q;
    sword_d = sword_q;
    ready_d = ready_q;
    sboxw   = 32'h0;
    case (state_q)
      CTRL_IDLE: begin
        if (next) begin
          round_d = 4'd0;
          ready_d = 1'b0;
          state_d = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        w_d     = block ^ round_key;
        round_d = 4'd1;
        sword_d = 2'd0;
        state_d = CTRL_SBOX;
      end
      CTRL_SBOX: begin
`ifdef AES_ENC_SBOX_PARALLEL_EN
        w_d     = sub_all;
        state_d = CTRL_MAIN;
`else
        sboxw          = w_q[sword_q];
        w_d[sword_q]   = new_sboxw;
        sword_d        = sword_q + 2'd1;
        if (sword_q == 2'd3) state_d = CTRL_MAIN;
`endif
      end
      CTRL_MAIN: begin
        sword_d = 2'd0;
        // The last round skips MixColumns and hands the result back.
        if (round_q < nr) begin
          w_d     = mix_columns(shift_rows(w_q)) ^ round_key;
          round_d = round_q + 4'd1;
          state_d = CTRL_SBOX;
        end else begin
          w_d     = shift_rows(w_q) ^ round_key;
          ready_d = 1'b1;
          state_d = CTRL_IDLE;
        end
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Bench for aes_encipher_block: external S-box and key memory models, byte-level AES reference.
module tb_aes_encipher_block;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

`ifdef AES_ENC_SBOX_PARALLEL_EN
  localparam int ROUND_CYC = 2;
`else
  localparam int ROUND_CYC = 5;
`endif

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic [7:0]   sbox [256];
  logic [127:0] rk   [16];
  int           err_cnt = 0;
  int           chk_cnt = 0;

  aes_encipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    new_sboxw = {sbox[sboxw[31:24]], sbox[sboxw[23:16]], sbox[sboxw[15:8]], sbox[sboxw[7:0]]};
    round_key = rk[round];
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table generated by walking generator 3 and its inverse through GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic kl, input logic [255:0] key);
    logic [31:0] wk [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) wk[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = wk[i - 1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      wk[i] = wk[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {wk[4 * r], wk[4 * r + 1], wk[4 * r + 2], wk[4 * r + 3]} : 128'h0;
  endtask

  // Byte-array AES over the currently expanded round keys; byte 4c+r is row r of column c.
  function automatic logic [127:0] model(input int nr, input logic [127:0] blk);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = blk[127 - 8 * i -: 8] ^ rk[0][127 - 8 * i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4 * c + rr] = s[4 * ((c + rr) % 4) + rr];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
        if (r < nr) begin
          s[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8 * i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  task automatic waitReady(input string tag, output int cycles);
    cycles = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (ready) begin
        cycles = n;
        break;
      end
    end
    if (cycles < 0) checkOutput({tag, "_timeout"}, 128'd0, 128'd1);
  endtask

  // kind 0: plain run; kind 1: extra next pulse at disturb_round; kind 2: reset at disturb_round.
  task automatic applyStimulus(input string tag, input logic kl, input logic [255:0] key,
                               input logic [127:0] blk, input int disturb_round, input int kind,
                               output logic [127:0] res, output int cycles);
    int  nr, prev;
    bit  seq_ok, injected, pulse_on;
    nr = kl ? 14 : 10;
    expand_key(kl, key);
    keylen = kl;
    block  = blk;
    @(negedge clk) next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    checkOutput({tag, "_ready_low"}, 128'(ready), 128'd0);
    checkOutput({tag, "_init_round"}, 128'(round), 128'd0);
    checkOutput({tag, "_init_sboxw"}, 128'(sboxw), 128'd0);
    prev = 0; seq_ok = 1'b1; injected = 1'b0; pulse_on = 1'b0;
    cycles = -1;
    res = 'x;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (pulse_on) begin next = 1'b0; pulse_on = 1'b0; end
      if (int'(round) != prev && int'(round) != prev + 1) seq_ok = 1'b0;
      prev = int'(round);
      if (!injected && kind != 0 && int'(round) == disturb_round) begin
        injected = 1'b1;
        if (kind == 1) begin
          next = 1'b1; block = ~blk; pulse_on = 1'b1;
        end else begin
          reset_n = 1'b0;
          #1;
          checkOutput({tag, "_rst_ready"}, 128'(ready), 128'd1);
          checkOutput({tag, "_rst_round"}, 128'(round), 128'd0);
          checkOutput({tag, "_rst_block"}, new_block, 128'h0);
          @(negedge clk) reset_n = 1'b1;
          return;
        end
      end
      if (ready) begin
        cycles = n;
        res = new_block;
        break;
      end
    end
    if (cycles < 0) checkOutput({tag, "_timeout"}, 128'd0, 128'd1);
    checkOutput({tag, "_latency"}, 128'(cycles), 128'(1 + ROUND_CYC * nr));
    checkOutput({tag, "_round_seq"}, 128'(seq_ok && prev == nr), 128'd1);
    checkOutput({tag, "_model"}, res, model(nr, blk));
  endtask

  initial begin
    logic [127:0] res, blk_a, blk_b;
    logic [255:0] key;
    logic         kl;
    int           cyc;

    reset_n = 1'b0; next = 1'b0; keylen = 1'b0; block = '0;
    build_sbox();
    expand_key(1'b0, KEY_C1);
    #12;
    checkOutput("reset_block", new_block, 128'h0);
    checkOutput("reset_ready", 128'(ready), 128'd1);
    checkOutput("reset_round", 128'(round), 128'd0);
    checkOutput("reset_sboxw", 128'(sboxw), 128'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_ready", 128'(ready), 128'd1);

    applyStimulus("c1", 1'b0, KEY_C1, PT, -1, 0, res, cyc);
    checkOutput("c1_vector", res, CT_C1);
    repeat (3) @(negedge clk);
    checkOutput("c1_hold", new_block, CT_C1);
    checkOutput("c1_idle_sboxw", 128'(sboxw), 128'd0);

    applyStimulus("c3", 1'b1, KEY_C3, PT, -1, 0, res, cyc);
    checkOutput("c3_vector", res, CT_C3);

    applyStimulus("ignore_next", 1'b0, KEY_C1, PT, 5, 1, res, cyc);
    checkOutput("ignore_next_vector", res, CT_C1);

    applyStimulus("midreset", 1'b0, KEY_C1, PT, 3, 2, res, cyc);
    applyStimulus("after_rst", 1'b0, KEY_C1, PT, -1, 0, res, cyc);
    checkOutput("after_rst_vector", res, CT_C1);

    // Back-to-back with next held high: the second op starts on the edge after ready.
    blk_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    blk_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand_key(1'b0, KEY_C1);
    keylen = 1'b0;
    block  = blk_a;
    @(negedge clk) next = 1'b1;
    waitReady("b2b_first", cyc);
    checkOutput("b2b_first_latency", 128'(cyc), 128'(2 + ROUND_CYC * 10));
    checkOutput("b2b_first_model", new_block, model(10, blk_a));
    block = blk_b;
    @(posedge clk); #1;
    checkOutput("b2b_restart", 128'(ready), 128'd0);
    next = 1'b0;
    waitReady("b2b_second", cyc);
    checkOutput("b2b_second_latency", 128'(cyc), 128'(1 + ROUND_CYC * 10));
    checkOutput("b2b_second_model", new_block, model(10, blk_b));

    for (int k = 0; k < 6; k++) begin
      kl  = 1'($urandom_range(0, 1));
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      if (!kl) key[127:0] = '0;
      blk_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus($sformatf("rand%0d", k), kl, key, blk_a, -1, 0, res, cyc);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
